// File: rtl/foo_pipeline_pkg.sv
// Shared constants and per-stage arithmetic for the foo elastic pipeline.
package foo_pipeline_pkg;

  localparam int unsigned FOO_DEFAULT_WIDTH  = 32;
  localparam int unsigned FOO_DEFAULT_STAGES = 2;
  localparam int unsigned FOO_MAX_WIDTH      = 64;

  // Stage 0 adds one; later stages add two by bumping bits above bit 0.
  // Callers truncate the result to their width, which gives the modulo wrap.
  function automatic logic [FOO_MAX_WIDTH-1:0] foo_stage_op(
    input int unsigned              stage_idx,
    input logic [FOO_MAX_WIDTH-1:0] d
  );
    logic [FOO_MAX_WIDTH-1:0] r;
    if (stage_idx == 0) begin
      r = d + FOO_MAX_WIDTH'(1);
    end else begin
      r = {d[FOO_MAX_WIDTH-1:1] + (FOO_MAX_WIDTH-1)'(1), d[0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/foo_pipe_slot.sv
// One elastic pipeline slot: valid/data register that loads the (optionally
// transformed) upstream value whenever its advance input is high.
module foo_pipe_slot
  import foo_pipeline_pkg::*;
#(
  parameter int unsigned WIDTH     = FOO_DEFAULT_WIDTH,
  parameter int unsigned STAGE_IDX = 0,
  parameter bit          HAS_OP    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] op_c;

  always_comb begin
    op_c = up_data;
    if (HAS_OP) begin
      op_c = WIDTH'(foo_stage_op(STAGE_IDX, FOO_MAX_WIDTH'(up_data)));
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (adv) begin
      valid_d = up_valid;
      data_d  = op_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Data path is deliberately not reset; valid qualifies it.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/foo_pipeline_elastic.sv
// Elastic ready/valid foo pipeline with bubble collapsing (WIDTH <= 64).
// Optional occupancy counter port enabled by FOO_PIPELINE_ELASTIC_OCCUPANCY_EN.
module foo_pipeline_elastic
  import foo_pipeline_pkg::*;
#(
  parameter int unsigned WIDTH      = FOO_DEFAULT_WIDTH,
  parameter int unsigned NUM_STAGES = FOO_DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef FOO_PIPELINE_ELASTIC_OCCUPANCY_EN
  ,
  output logic [$clog2(NUM_STAGES+2)-1:0] occupancy
`endif
);

  localparam int unsigned DEPTH = NUM_STAGES + 1;

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv_c;
  logic [WIDTH-1:0] d [DEPTH];

  // A slot may load when it is empty or the slot below it is loading.
  always_comb begin
    logic chain;
    adv_c = '0;
    chain = out_ready | ~v[DEPTH-1];
    adv_c[DEPTH-1] = chain;
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      chain    = ~v[k] | chain;
      adv_c[k] = chain;
    end
  end

  for (genvar k = 0; k < int'(DEPTH); k++) begin : g_slot
    if (k == 0) begin : g_in
      foo_pipe_slot #(
        .WIDTH    (WIDTH),
        .STAGE_IDX(0),
        .HAS_OP   (1'b0)
      ) u_slot (
        .clk     (clk),
        .rst     (rst),
        .adv     (adv_c[0]),
        .up_valid(in_valid),
        .up_data (in_data),
        .valid   (v[0]),
        .data    (d[0])
      );
    end else begin : g_stage
      foo_pipe_slot #(
        .WIDTH    (WIDTH),
        .STAGE_IDX(k - 1),
        .HAS_OP   (1'b1)
      ) u_slot (
        .clk     (clk),
        .rst     (rst),
        .adv     (adv_c[k]),
        .up_valid(v[k-1]),
        .up_data (d[k-1]),
        .valid   (v[k]),
        .data    (d[k])
      );
    end
  end

  assign in_ready  = rst | adv_c[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

`ifdef FOO_PIPELINE_ELASTIC_OCCUPANCY_EN
  localparam int unsigned OCC_W = $clog2(NUM_STAGES + 2);

  logic [OCC_W-1:0] occ_q, occ_d;
  logic             in_xfer_c, out_xfer_c;

  // Counter tracks items held; simultaneous in/out leaves it unchanged.
  always_comb begin
    in_xfer_c  = in_valid & in_ready;
    out_xfer_c = out_valid & out_ready;
    occ_d      = occ_q;
    if (in_xfer_c && !out_xfer_c) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (out_xfer_c && !in_xfer_c) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_foo_pipeline_elastic.sv
// Self-checking bench for foo_pipeline_elastic against a FIFO reference model.
module tb_foo_pipeline_elastic;

  localparam int unsigned W     = 32;
  localparam int unsigned NS    = 2;
  localparam int unsigned DEPTH = NS + 1;
  localparam int unsigned W8    = 8;
  localparam int unsigned NS8   = 3;

  logic          clk;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic          iv8, ir8, ov8, ordy8;
  logic [W8-1:0] d8, od8;
`ifdef FOO_PIPELINE_ELASTIC_OCCUPANCY_EN
  logic [$clog2(NS+2)-1:0]  occupancy;
  logic [$clog2(NS8+2)-1:0] occ8;
`endif

  foo_pipeline_elastic #(.WIDTH(W), .NUM_STAGES(NS)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef FOO_PIPELINE_ELASTIC_OCCUPANCY_EN
    ,
    .occupancy(occupancy)
`endif
  );

  foo_pipeline_elastic #(.WIDTH(W8), .NUM_STAGES(NS8)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (iv8),
    .in_ready (ir8),
    .in_data  (d8),
    .out_valid(ov8),
    .out_ready(ordy8),
    .out_data (od8)
`ifdef FOO_PIPELINE_ELASTIC_OCCUPANCY_EN
    ,
    .occupancy(occ8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] val;
    int           entry;
  } item_t;

  item_t        q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           acc = 0;
  int           outs = 0;
  bit           exact_lat = 1'b0;
  bit           hold_prev = 1'b0;
  logic [W-1:0] held = '0;

  // Result = x + 1 + 2*(NS-1), wrapped to W bits.
  function automatic logic [W-1:0] ref_out(input logic [W-1:0] x);
    logic [63:0] t;
    t = 64'(x) + 64'(1 + 2 * (NS - 1));
    return t[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle: drive inputs, check against the model, update the model.
  task automatic step(input bit r, input bit iv, input logic [W-1:0] x, input bit ordy);
    item_t h;
    bit    ixf, oxf;
    @(negedge clk);
    rst = r; in_valid = iv; in_data = x; out_ready = ordy;
    #1;
    if (r) begin
      chk("in_ready_in_reset", 64'(in_ready), 64'(1));
      q.delete();
      hold_prev = 1'b0;
    end else begin
      chk("in_ready", 64'(in_ready), 64'((q.size() < int'(DEPTH)) || ordy));
`ifdef FOO_PIPELINE_ELASTIC_OCCUPANCY_EN
      chk("occupancy", 64'(occupancy), 64'(q.size()));
`endif
      if (q.size() == 0) chk("no_phantom_valid", 64'(out_valid), 64'(0));
      if (hold_prev) begin
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_data", 64'(out_data), 64'(held));
      end
      oxf = out_valid && ordy;
      ixf = iv && in_ready;
      if (oxf && q.size() != 0) begin
        h = q.pop_front();
        outs++;
        chk("out_data", 64'(out_data), 64'(h.val));
        if (exact_lat) chk("latency", 64'(cyc - h.entry), 64'(DEPTH));
        else chk("min_latency", 64'((cyc - h.entry) >= int'(DEPTH)), 64'(1));
      end
      if (ixf) begin
        q.push_back('{ref_out(x), cyc});
        acc++;
      end
      hold_prev = out_valid && !ordy;
      held      = out_data;
    end
    cyc++;
  endtask

  function automatic logic [W-1:0] rand_word();
    int unsigned sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return '1;
    if (sel == 1) return W'(32'hFFFF_FFFE);
    if (sel == 2) return '0;
    return W'($urandom());
  endfunction

  initial begin
    int           acc0, outs0;
    bit           seen;
    logic [W8-1:0] exp8;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    iv8 = 1'b0; d8 = '0; ordy8 = 1'b1;

    // Reset and idle state
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("reset_out_valid", 64'(out_valid), 64'(0));

    // Back-to-back streaming with exact latency
    exact_lat = 1'b1;
    step(1'b0, 1'b1, W'(0), 1'b1);
    step(1'b0, 1'b1, W'(5), 1'b1);
    step(1'b0, 1'b1, W'(32'hFFFF_FFFF), 1'b1);
    repeat (5) step(1'b0, 1'b0, '0, 1'b1);
    exact_lat = 1'b0;
    chk("stream_drained", 64'(q.size()), 64'(0));
    chk("stream_outputs", 64'(outs), 64'(3));

    // Backpressure fill, then drain in order
    acc = 0;
    repeat (6) step(1'b0, 1'b1, rand_word(), 1'b0);
    chk("fill_accepted", 64'(acc), 64'(DEPTH));
    chk("fill_in_ready_low", 64'(in_ready), 64'(0));
    repeat (DEPTH + 2) step(1'b0, 1'b0, '0, 1'b1);
    chk("fill_drained", 64'(q.size()), 64'(0));

    // Simultaneous in/out while full
    repeat (DEPTH) step(1'b0, 1'b1, rand_word(), 1'b0);
    acc0 = acc; outs0 = outs;
    step(1'b0, 1'b1, rand_word(), 1'b1);
    chk("full_xfer_in", 64'(acc - acc0), 64'(1));
    chk("full_xfer_out", 64'(outs - outs0), 64'(1));
    step(1'b0, 1'b0, '0, 1'b0);
    chk("full_still_full", 64'(q.size()), 64'(DEPTH));
    repeat (DEPTH + 2) step(1'b0, 1'b0, '0, 1'b1);

    // Mid-flight reset discards in-flight items
    step(1'b0, 1'b1, rand_word(), 1'b0);
    step(1'b0, 1'b1, rand_word(), 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("post_reset_out_valid", 64'(out_valid), 64'(0));
    repeat (8) step(1'b0, 1'b0, '0, 1'b1);

    // Bubble collapse under a stalled output
    acc = 0;
    step(1'b0, 1'b1, rand_word(), 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, rand_word(), 1'b0);
    step(1'b0, 1'b1, rand_word(), 1'b0);
    step(1'b0, 1'b1, rand_word(), 1'b0);
    chk("bubble_accepted", 64'(acc), 64'(DEPTH));
    repeat (DEPTH + 2) step(1'b0, 1'b0, '0, 1'b1);

    // Random traffic, then bounded drain
    repeat (400) step(1'b0, $urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 2) != 0);
    for (int i = 0; i < 20 && q.size() != 0; i++) step(1'b0, 1'b0, '0, 1'b1);
    chk("final_drain", 64'(q.size()), 64'(0));

    // Narrow instance: wrap and bit-0 pass-through
    exp8 = W8'(16'h00FE + 16'(1 + 2 * (NS8 - 1)));
    @(negedge clk);
    iv8 = 1'b1; d8 = 8'hFE;
    #1;
    chk("w8_in_ready", 64'(ir8), 64'(1));
    @(negedge clk);
    iv8 = 1'b0;
    #1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (!seen && ov8) begin
        seen = 1'b1;
        chk("w8_out_data", 64'(od8), 64'(exp8));
      end
      @(negedge clk);
      #1;
    end
    chk("w8_seen", 64'(seen), 64'(1));
`ifdef FOO_PIPELINE_ELASTIC_OCCUPANCY_EN
    chk("w8_occupancy", 64'(occ8), 64'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
